// File: rtl/park_pkg.sv
// Shared constants, count-action encoding and action decoder for the parking-lot occupancy controller.
package park_pkg;

   localparam int unsigned PARK_DEFAULT_CAPACITY = 15;
   localparam int unsigned PARK_DEFAULT_PULSE    = 4;

   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_INC,
      ACT_DEC,
      ACT_REJECT,
      ACT_UNDERFLOW
   } park_act_e;

   // Simultaneous entry and exit cancel out, even at the full/empty limits.
   function automatic park_act_e park_decode(input logic i_enter_rise,
                                             input logic i_exit_rise,
                                             input logic i_is_full,
                                             input logic i_is_empty);
      park_act_e w_act;
      w_act = ACT_HOLD;
      if (i_enter_rise && !i_exit_rise) begin
         w_act = i_is_full ? ACT_REJECT : ACT_INC;
      end else if (i_exit_rise && !i_enter_rise) begin
         w_act = i_is_empty ? ACT_UNDERFLOW : ACT_DEC;
      end
      return w_act;
   endfunction

endpackage

// File: rtl/park_edge_det.sv
// Rising-edge detector for one gate sensor, with an optional 2-flop input
// synchronizer enabled by PARK_SENSOR_SYNC_EN.
module park_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic i_sensor,
   output logic o_rise_c
);

   logic w_sampled;
   logic r_prev;

`ifdef PARK_SENSOR_SYNC_EN
   logic [1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], i_sensor};
      end
   end

   assign w_sampled = r_sync[1];
`else
   assign w_sampled = i_sensor;
`endif

   // Tracks the sampled level in and out of reset so a held sensor gives no edge.
   always_ff @(posedge clk) begin
      r_prev <= w_sampled;
   end

   assign o_rise_c = w_sampled & ~r_prev & ~rst;

endmodule

// File: rtl/park_occupancy_ctrl.sv
// Parking-lot occupancy counter with full/empty flags, underflow pulse and a
// retriggerable reject-light stretcher. Sensor sync via PARK_SENSOR_SYNC_EN.
module park_occupancy_ctrl
   import park_pkg::*;
#(
   parameter  int unsigned CAPACITY     = PARK_DEFAULT_CAPACITY,
   parameter  int unsigned PULSE_CYCLES = PARK_DEFAULT_PULSE,
   localparam int unsigned COUNT_W      = $clog2(CAPACITY + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enter_sensor,
   input  logic               exit_sensor,
   output logic [COUNT_W-1:0] count,
   output logic               full,
   empty,
   output logic               reject_light,
   output logic               underflow
);

   localparam int unsigned PULSE_W = $clog2(PULSE_CYCLES + 1);

   logic               w_enter_rise;
   logic               w_exit_rise;
   park_act_e          w_act;
   logic [COUNT_W-1:0] r_count;
   logic [COUNT_W-1:0] w_count_nxt;
   logic [PULSE_W-1:0] r_stretch;
   logic [PULSE_W-1:0] w_stretch_nxt;
   logic               r_full;
   logic               r_empty;
   logic               r_reject_light;
   logic               r_underflow;

   park_edge_det u_enter_edge (
      .clk      (clk),
      .rst      (rst),
      .i_sensor (enter_sensor),
      .o_rise_c (w_enter_rise)
   );

   park_edge_det u_exit_edge (
      .clk      (clk),
      .rst      (rst),
      .i_sensor (exit_sensor),
      .o_rise_c (w_exit_rise)
   );

   // Next count and stretcher value from the decoded action.
   always_comb begin
      w_act         = park_decode(w_enter_rise, w_exit_rise, r_full, r_empty);
      w_count_nxt   = r_count;
      w_stretch_nxt = (r_stretch != '0) ? r_stretch - PULSE_W'(1) : r_stretch;
      case (w_act)
         ACT_INC:    w_count_nxt   = r_count + COUNT_W'(1);
         ACT_DEC:    w_count_nxt   = r_count - COUNT_W'(1);
         ACT_REJECT: w_stretch_nxt = PULSE_W'(PULSE_CYCLES);
         default:    w_count_nxt   = r_count;
      endcase
   end

   // Flags are derived from the next count so they line up with it cycle for cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count        <= '0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_stretch      <= '0;
         r_reject_light <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         r_count        <= w_count_nxt;
         r_full         <= (w_count_nxt == COUNT_W'(CAPACITY));
         r_empty        <= (w_count_nxt == '0);
         r_stretch      <= w_stretch_nxt;
         r_reject_light <= (w_stretch_nxt != '0);
         r_underflow    <= (w_act == ACT_UNDERFLOW);
      end
   end

   assign count        = r_count;
   assign full         = r_full;
   assign empty        = r_empty;
   assign reject_light = r_reject_light;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_park_occupancy_ctrl.sv
// Self-checking bench for park_occupancy_ctrl (CAPACITY=3, PULSE_CYCLES=4);
// follows PARK_SENSOR_SYNC_EN for sensor latency.
module tb_park_occupancy_ctrl;

   localparam int CAP   = 3;
   localparam int PULSE = 4;

   logic       clk;
   logic       rst;
   logic       enter_sensor;
   logic       exit_sensor;
   logic [1:0] count;
   logic       full;
   logic       empty;
   logic       reject_light;
   logic       underflow;

   int n_tests = 0;
   int n_fail  = 0;

   park_occupancy_ctrl #(
      .CAPACITY     (CAP),
      .PULSE_CYCLES (PULSE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enter_sensor (enter_sensor),
      .exit_sensor  (exit_sensor),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .reject_light (reject_light),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: occupancy as an integer, reject light as cycles remaining.
   int       m_count;
   int       m_rej;
   bit       m_under;
   bit       m_valid = 1'b0;
   bit       m_prev_en;
   bit       m_prev_ex;
   bit [1:0] m_pipe_en = 2'b00;
   bit [1:0] m_pipe_ex = 2'b00;

   always @(posedge clk) begin
      bit s_en, s_ex, er, xr, rej;
`ifdef PARK_SENSOR_SYNC_EN
      s_en = m_pipe_en[1];
      s_ex = m_pipe_ex[1];
`else
      s_en = enter_sensor;
      s_ex = exit_sensor;
`endif
      if (rst) begin
         m_count = 0;
         m_rej   = 0;
         m_under = 1'b0;
         m_valid = 1'b1;
      end else begin
         er      = s_en && !m_prev_en;
         xr      = s_ex && !m_prev_ex;
         rej     = 1'b0;
         m_under = 1'b0;
         if (er && !xr) begin
            if (m_count < CAP) m_count = m_count + 1;
            else rej = 1'b1;
         end else if (xr && !er) begin
            if (m_count > 0) m_count = m_count - 1;
            else m_under = 1'b1;
         end
         if (rej) m_rej = PULSE;
         else if (m_rej > 0) m_rej = m_rej - 1;
      end
      m_prev_en = s_en;
      m_prev_ex = s_ex;
      if (rst) begin
         m_pipe_en = 2'b00;
         m_pipe_ex = 2'b00;
      end else begin
         m_pipe_en = {m_pipe_en[0], enter_sensor};
         m_pipe_ex = {m_pipe_ex[0], exit_sensor};
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_count", int'(count), m_count);
         chk("model_full", int'(full), int'(m_count == CAP));
         chk("model_empty", int'(empty), int'(m_count == 0));
         chk("model_reject_light", int'(reject_light), int'(m_rej > 0));
         chk("model_underflow", int'(underflow), int'(m_under));
      end
   end

   // Drive one sensor pulse for a cycle and count light/underflow cycles over the following window.
   task automatic stim(input logic en, input logic ex, output int lc, output int uc);
      lc = 0;
      uc = 0;
      enter_sensor = en;
      exit_sensor  = ex;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) begin
            enter_sensor = 1'b0;
            exit_sensor  = 1'b0;
         end
         lc += int'(reject_light);
         uc += int'(underflow);
      end
   endtask

   typedef struct packed {
      logic en;
      logic ex;
   } vec_t;

   vec_t vecs[16] = '{
      '{1'b1, 1'b0}, '{1'b0, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b0},
      '{1'b0, 1'b1}, '{1'b1, 1'b1}, '{1'b0, 1'b0}, '{1'b1, 1'b0},
      '{1'b0, 1'b0}, '{1'b1, 1'b0}, '{1'b0, 1'b0}, '{1'b1, 1'b1},
      '{1'b0, 1'b1}, '{1'b0, 1'b0}, '{1'b0, 1'b1}, '{1'b0, 1'b0}
   };

   initial begin
      int lc, uc, seen;
      rst          = 1'b1;
      enter_sensor = 1'b1;
      exit_sensor  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_count", int'(count), 0);
      chk("reset_empty", int'(empty), 1);
      rst = 1'b0;
      repeat (10) @(negedge clk);
`ifndef PARK_SENSOR_SYNC_EN
      chk("held_sensor_count", int'(count), 0);
      chk("held_sensor_empty", int'(empty), 1);
`endif
      chk("held_sensor_light", int'(reject_light), 0);

      enter_sensor = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         stim(1'b1, 1'b0, lc, uc);
         chk("fill_count", int'(count), (i < 3) ? i + 1 : 3);
         chk("fill_full", int'(full), int'(i >= 2));
         chk("fill_light_cycles", lc, (i == 3) ? 4 : 0);
      end

      stim(1'b1, 1'b1, lc, uc);
      chk("both_full_count", int'(count), 3);
      chk("both_full_light", lc, 0);

      stim(1'b0, 1'b1, lc, uc);
      chk("exit_count", int'(count), 2);
      chk("exit_full", int'(full), 0);

      stim(1'b0, 1'b1, lc, uc);
      stim(1'b0, 1'b1, lc, uc);
      chk("drain_count", int'(count), 0);
      stim(1'b0, 1'b1, lc, uc);
      chk("underflow_count", int'(count), 0);
      chk("underflow_cycles", uc, 1);
      chk("underflow_empty", int'(empty), 1);

      stim(1'b1, 1'b1, lc, uc);
      chk("both_empty_underflow", uc, 0);
      chk("both_empty_count", int'(count), 0);

      for (int i = 0; i < 3; i++) stim(1'b1, 1'b0, lc, uc);
      chk("refill_count", int'(count), 3);

      lc = 0;
      enter_sensor = 1'b1;
      @(negedge clk);
      lc += int'(reject_light);
      enter_sensor = 1'b0;
      @(negedge clk);
      lc += int'(reject_light);
      enter_sensor = 1'b1;
      @(negedge clk);
      lc += int'(reject_light);
      enter_sensor = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         lc += int'(reject_light);
      end
      chk("retrigger_light_cycles", lc, 6);
      chk("retrigger_count", int'(count), 3);

      seen = 0;
      enter_sensor = 1'b1;
      for (int i = 0; i < 6 && seen == 0; i++) begin
         @(negedge clk);
         enter_sensor = 1'b0;
         seen = int'(reject_light);
      end
      chk("midpulse_light_seen", seen, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midpulse_reset_light", int'(reject_light), 0);
      chk("midpulse_reset_count", int'(count), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) begin
         enter_sensor = vecs[i].en;
         exit_sensor  = vecs[i].ex;
         @(negedge clk);
      end
      enter_sensor = 1'b0;
      exit_sensor  = 1'b0;
      repeat (8) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
